// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the EX-stage multi-cycle MUL sequencer:
// ALU control code, FSM state encoding and a counter-width helper.
package mul_sequencer_pkg;

    localparam logic [3:0] MUL_ALU_CTRL = 4'b1000;

    typedef enum logic [1:0] {
        MULSEQ_IDLE = 2'd0,
        MULSEQ_BUSY = 2'd1,
        MULSEQ_DONE = 2'd2
    } mulseq_state_e;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Pipeline <-> MUL sequencer signal bundle. The pipeline side is the master
// and drives start/flush/operands; the sequencer answers with stall/busy/result/valid.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             valid;

    modport master (
        output start, flush, op_a, op_b,
        input  stall, busy, result, valid
    );

    modport slave (
        input  start, flush, op_a, op_b,
        output stall, busy, result, valid
    );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: accumulator, shifting multiplicand and
// multiplier registers. Sequenced by mul_sequencer through load/step.
module mul_shift_add_dp
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_next,
    output logic             mplier_zero
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // Looks at the multiplier as it will be after this step's shift, so the
    // FSM can stop on the same step that consumes the last set bit.
    assign mplier_zero = (mplier >> 1) == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// MUL sequencer for the EX-stage ALU: FSM, step counter and output registers
// around the shift-add datapath; stalls the pipeline until the product is ready.
//
// state       | meaning
// MULSEQ_IDLE | waiting for a MUL in EX; captures operands on start
// MULSEQ_BUSY | one shift-add step per cycle, pipeline stalled
// MULSEQ_DONE | result valid for one cycle, pipeline released
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    mul_sequencer_if.slave    bus
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    mulseq_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             valid_r;
    logic [WIDTH-1:0] result_r;

    logic             load;
    logic             step;
    logic             last_step;
    logic [WIDTH-1:0] acc_next;
    logic             mplier_zero;

    assign load      = (state == MULSEQ_IDLE) && bus.start && !bus.flush;
    assign step      = (state == MULSEQ_BUSY) && !bus.flush;
    assign last_step = (cnt == CNT_LAST) || (EARLY_EXIT && mplier_zero);

    // Low in DONE so EX/MEM captures result on the DONE edge.
    assign bus.stall = !rst && !bus.flush &&
                       (((state == MULSEQ_IDLE) && bus.start) || (state == MULSEQ_BUSY));

    assign bus.busy   = busy_r;
    assign bus.valid  = valid_r;
    assign bus.result = result_r;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .op_a        (bus.op_a),
        .op_b        (bus.op_b),
        .acc_next    (acc_next),
        .mplier_zero (mplier_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MULSEQ_IDLE;
            cnt      <= '0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= '0;
        end else if (bus.flush) begin
            state   <= MULSEQ_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                MULSEQ_IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.start) begin
                        state  <= MULSEQ_BUSY;
                        busy_r <= 1'b1;
                        cnt    <= '0;
                    end
                end
                MULSEQ_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        state    <= MULSEQ_DONE;
                        busy_r   <= 1'b0;
                        valid_r  <= 1'b1;
                        result_r <= acc_next;
                    end
                end
                MULSEQ_DONE: begin
                    state   <= MULSEQ_IDLE;
                    valid_r <= 1'b0;
                end
                default: begin
                    state   <= MULSEQ_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: one full-latency instance and one
// early-exit instance, with expected products queued at start and checked on valid.
module tb_mul_sequencer;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_sequencer_if #(.WIDTH(WIDTH)) bus_a ();
    mul_sequencer_if #(.WIDTH(WIDTH)) bus_b ();

    mul_sequencer #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mul_sequencer #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc_no  = 0;
    int stall_a = 0;
    int stall_b = 0;
    int valid_a = 0;
    int valid_b = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc_no++;

    always @(negedge clk) begin
        if (bus_a.stall === 1'b1) stall_a++;
        if (bus_a.valid === 1'b1) begin
            valid_a++;
            check("a_valid_expected", 32'(exp_a.size() > 0), 32'd1);
            if (exp_a.size() > 0) check("a_result", bus_a.result, exp_a.pop_front());
            check("a_stall_in_done", 32'(bus_a.stall), 32'd0);
        end
        if (bus_b.stall === 1'b1) stall_b++;
        if (bus_b.valid === 1'b1) begin
            valid_b++;
            check("b_valid_expected", 32'(exp_b.size() > 0), 32'd1);
            if (exp_b.size() > 0) check("b_result", bus_b.result, exp_b.pop_front());
            check("b_stall_in_done", 32'(bus_b.stall), 32'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_a(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus_a.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic wait_valid_b(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus_b.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    // One MUL on the full-latency instance; lat = cycles from accept to valid,
    // which also equals the number of stalled cycles.
    task automatic run_a(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input int lat);
        bit ok;
        int t0;
        int s0;
        bus_a.op_a  = a;
        bus_a.op_b  = b;
        bus_a.start = 1'b1;
        exp_a.push_back(prod);
        t0 = cyc_no;
        s0 = stall_a;
        wait_valid_a(lat + 10, ok);
        check({tag, "_valid_seen"}, 32'(ok), 32'd1);
        check({tag, "_latency"}, 32'(cyc_no - t0), 32'(lat));
        check({tag, "_busy_in_done"}, 32'(bus_a.busy), 32'd0);
        bus_a.start = 1'b0;
        cyc(1);
        check({tag, "_stall_cycles"}, 32'(stall_a - s0), 32'(lat));
    endtask

    task automatic run_b(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input int lat);
        bit ok;
        int t0;
        int s0;
        bus_b.op_a  = a;
        bus_b.op_b  = b;
        bus_b.start = 1'b1;
        exp_b.push_back(prod);
        t0 = cyc_no;
        s0 = stall_b;
        wait_valid_b(lat + 10, ok);
        check({tag, "_valid_seen"}, 32'(ok), 32'd1);
        check({tag, "_latency"}, 32'(cyc_no - t0), 32'(lat));
        bus_b.start = 1'b0;
        cyc(1);
        check({tag, "_stall_cycles"}, 32'(stall_b - s0), 32'(lat));
    endtask

    initial begin
        bit ok;
        int t1;
        int v0;

        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_a.flush = 1'b0;
        bus_a.op_a  = '0;
        bus_a.op_b  = '0;
        bus_b.start = 1'b0;
        bus_b.flush = 1'b0;
        bus_b.op_a  = '0;
        bus_b.op_b  = '0;
        cyc(2);

        // Reset state, with start already asserted to show reset gates stall.
        bus_a.start = 1'b1;
        #1;
        check("rst_stall", 32'(bus_a.stall), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_valid", 32'(bus_a.valid), 32'd0);
        check("rst_result", bus_a.result, 32'd0);
        cyc(1);
        rst = 1'b0;

        v0 = valid_a;
        run_a("mul_3x5", 32'd3, 32'd5, 32'd15, 33);
        check("mul_3x5_one_valid", 32'(valid_a - v0), 32'd1);

        run_a("mul_ffff_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_a("mul_wrap", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);

        // Back-to-back: second MUL offered during DONE, accepted in the next IDLE.
        v0 = valid_a;
        bus_a.op_a  = 32'd7;
        bus_a.op_b  = 32'd6;
        bus_a.start = 1'b1;
        exp_a.push_back(32'd42);
        wait_valid_a(50, ok);
        check("b2b_first_seen", 32'(ok), 32'd1);
        t1 = cyc_no;
        bus_a.op_a = 32'h1234;
        bus_a.op_b = 32'h10;
        exp_a.push_back(32'h0001_2340);
        cyc(1);
        check("b2b_second_accept_stall", 32'(bus_a.stall), 32'd1);
        wait_valid_a(50, ok);
        check("b2b_second_seen", 32'(ok), 32'd1);
        check("b2b_spacing", 32'(cyc_no - t1), 32'd34);
        bus_a.start = 1'b0;
        cyc(1);
        check("b2b_valid_count", 32'(valid_a - v0), 32'd2);

        // Flush in the 10th BUSY cycle.
        v0 = valid_a;
        bus_a.op_a  = 32'd9;
        bus_a.op_b  = 32'd9;
        bus_a.start = 1'b1;
        cyc(10);
        check("flush_busy_before", 32'(bus_a.busy), 32'd1);
        bus_a.flush = 1'b1;
        #1;
        check("flush_busy_stall_drop", 32'(bus_a.stall), 32'd0);
        cyc(1);
        bus_a.flush = 1'b0;
        bus_a.start = 1'b0;
        check("flush_busy_idle", 32'(bus_a.busy), 32'd0);
        check("flush_busy_no_valid", 32'(bus_a.valid), 32'd0);
        cyc(40);
        check("flush_busy_valid_count", 32'(valid_a - v0), 32'd0);

        // Flush in DONE: that cycle's valid/result stands, nothing follows.
        bus_a.start = 1'b1;
        exp_a.push_back(32'h0000_0051);
        wait_valid_a(50, ok);
        check("flush_done_seen", 32'(ok), 32'd1);
        bus_a.flush = 1'b1;
        bus_a.start = 1'b0;
        #1;
        check("flush_done_valid_kept", 32'(bus_a.valid), 32'd1);
        cyc(1);
        bus_a.flush = 1'b0;
        check("flush_done_after_valid", 32'(bus_a.valid), 32'd0);
        check("flush_done_after_busy", 32'(bus_a.busy), 32'd0);

        // Reset in the middle of BUSY.
        v0 = valid_a;
        bus_a.op_a  = 32'h55;
        bus_a.op_b  = 32'h2;
        bus_a.start = 1'b1;
        cyc(5);
        check("rst_mid_busy_before", 32'(bus_a.busy), 32'd1);
        rst         = 1'b1;
        bus_a.start = 1'b0;
        cyc(1);
        check("rst_mid_busy", 32'(bus_a.busy), 32'd0);
        check("rst_mid_valid", 32'(bus_a.valid), 32'd0);
        check("rst_mid_result", bus_a.result, 32'd0);
        check("rst_mid_stall", 32'(bus_a.stall), 32'd0);
        rst = 1'b0;
        cyc(40);
        check("rst_mid_no_valid", 32'(valid_a - v0), 32'd0);

        // Early-exit instance.
        run_b("ee_7x3", 32'd7, 32'd3, 32'd21, 3);
        run_b("ee_b_zero", 32'd5, 32'd0, 32'd0, 2);
        run_b("ee_b_msb", 32'd3, 32'h8000_0000, 32'h8000_0000, 33);
        run_b("ee_0x1234x0x10", 32'h1234, 32'h10, 32'h0001_2340, 6);

        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
